multich_delay_sum_core: RTL and testbench

Parametrised successor to the three-slice delay beamformer. It fetches packed NUM_CH-channel filtered words from the filter output RAM and applies a programmable integer sample delay per channel. It accumulates the signed delay-and-sum and streams results through a valid/ready handshake toward the sum output RAM. It replaces the fixed slice_state mux and the externally driven sample_index with an internal sequencer.

---
 rtl/multich_delay_sum_core_pkg.sv | 30 +++
 rtl/multich_delay_sum_core_if.sv | 46 ++++
 rtl/multich_delay_sum_core_delay_line_ram.sv | 27 ++
 rtl/multich_delay_sum_core.sv | 161 ++++++++++++++++
 tb/tb_multich_delay_sum_core.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multich_delay_sum_core_pkg.sv
// Shared types and constants for the multichannel delay-and-sum core.
package bf_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 64;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        ACC,
        EMIT,
        FIN
    } state_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/multich_delay_sum_core_if.sv
// Control, filter-RAM read and result-stream signals of the delay-and-sum core.
interface multich_delay_sum_core_if #(
    parameter int NUM_CH  = bf_pkg::NUM_CH_DEF,
    parameter int DATA_W  = bf_pkg::DATA_W_DEF,
    parameter int ADDR_W  = 11,
    parameter int DELAY_W = 6
);
    import bf_pkg::*;

    localparam int CH_W  = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
    localparam int ACC_W = DATA_W + clog2(NUM_CH);

    logic                       start;
    logic [ADDR_W-1:0]          frame_len;
    logic                       dly_wr_en;
    logic [CH_W-1:0]            dly_wr_ch;
    logic [DELAY_W-1:0]         dly_wr_val;

    logic                       ram_rd_en;
    logic [ADDR_W-1:0]          ram_rd_addr;
    logic [NUM_CH*DATA_W-1:0]   ram_rd_data;

    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_W-1:0]           out_data;
    logic [ADDR_W-1:0]          out_index;

    logic                       busy;
    logic                       done;
    logic                       cfg_err;

    modport master (
        output start, frame_len, dly_wr_en, dly_wr_ch, dly_wr_val,
        output ram_rd_data, out_ready,
        input  ram_rd_en, ram_rd_addr, out_valid, out_data, out_index,
        input  busy, done, cfg_err
    );

    modport slave (
        input  start, frame_len, dly_wr_en, dly_wr_ch, dly_wr_val,
        input  ram_rd_data, out_ready,
        output ram_rd_en, ram_rd_addr, out_valid, out_data, out_index,
        output busy, done, cfg_err
    );

endinterface

// File: rtl/multich_delay_sum_core_delay_line_ram.sv
// Per-channel sample history: DEPTH x DATA_W array, one synchronous write port, one combinational read port.
module delay_line_ram #(
    parameter int DEPTH  = bf_pkg::DEPTH_DEF,
    parameter int DATA_W = bf_pkg::DATA_W_DEF,
    parameter int ADDR_W = bf_pkg::clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: no reset on the array; stale entries are never summed because
    // the sequencer masks any term whose delayed index precedes sample 0.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/multich_delay_sum_core.sv
// Sequenced delay-and-sum: reads packed channel words, delays each channel, streams signed sums.
module multich_delay_sum_core
    import bf_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = 11,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DELAY_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    multich_delay_sum_core_if.slave  io_bus
);

    localparam int CH_W  = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
    localparam int ACC_W = DATA_W + clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST_K = CH_W'(NUM_CH - 1);

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_n;
    logic [ADDR_W-1:0]         r_len;
    logic [CH_W-1:0]           r_k;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DELAY_W-1:0]        r_dly [NUM_CH];
    logic                      r_rd_en;
    logic                      r_valid;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_cfg_err;

    logic                      w_hist_we;
    logic [DELAY_W-1:0]        w_rd_addr [NUM_CH];
    logic [DATA_W-1:0]         w_rd_data [NUM_CH];
    logic [DATA_W-1:0]         w_sel_data;
    logic [DELAY_W-1:0]        w_sel_dly;
    logic signed [ACC_W-1:0]   w_term;

    assign w_hist_we = (r_state == WAIT);

    // History index wraps mod DEPTH simply by truncating to DELAY_W bits.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_hist
        assign w_rd_addr[c] = r_n[DELAY_W-1:0] - r_dly[c];

        delay_line_ram #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .ADDR_W (DELAY_W)
        ) u_hist (
            .clk       (clk),
            .i_wr_en   (w_hist_we),
            .i_wr_addr (r_n[DELAY_W-1:0]),
            .i_wr_data (io_bus.ram_rd_data[c*DATA_W +: DATA_W]),
            .i_rd_addr (w_rd_addr[c]),
            .o_rd_data (w_rd_data[c])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sel_data = w_rd_data[r_k];
        w_sel_dly  = r_dly[r_k];
        w_term     = '0;
        if (r_n >= ADDR_W'(w_sel_dly)) begin
            w_term = ACC_W'($signed(w_sel_data));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_len     <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_rd_en   <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_dly[c] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (io_bus.start) begin
                        r_len     <= io_bus.frame_len;
                        r_n       <= '0;
                        r_cfg_err <= 1'b0;
                        r_busy    <= 1'b1;
                        if (io_bus.frame_len == '0) begin
                            r_state <= FIN;
                        end else begin
                            r_state <= READ;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_rd_en <= 1'b0;
                    r_acc   <= '0;
                    r_k     <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_state <= ACC;
                end
                ACC: begin
                    r_acc <= r_acc + w_term;
                    r_k   <= r_k + 1'b1;
                    if (r_k == LAST_K) begin
                        r_state <= EMIT;
                        r_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (io_bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_n     <= r_n + 1'b1;
                        if (r_n == r_len - 1'b1) begin
                            r_state <= FIN;
                        end else begin
                            r_state <= READ;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Delay writes land only while idle; anything else flags a config error.
            if (io_bus.dly_wr_en) begin
                if (r_state != IDLE || int'(io_bus.dly_wr_ch) >= NUM_CH) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_dly[io_bus.dly_wr_ch] <= io_bus.dly_wr_val;
                end
            end
        end
    end

    assign io_bus.ram_rd_en   = r_rd_en;
    assign io_bus.ram_rd_addr = r_n;
    assign io_bus.out_valid   = r_valid;
    assign io_bus.out_data    = r_acc;
    assign io_bus.out_index   = r_n;
    assign io_bus.busy        = r_busy;
    assign io_bus.done        = r_done;
    assign io_bus.cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_multich_delay_sum_core.sv
// Directed bench for multich_delay_sum_core: filter-RAM model, expected sums, handshake and error rules.
module tb_multich_delay_sum_core;
    import bf_pkg::*;

    localparam int NUM_CH  = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 11;
    localparam int DEPTH   = 64;
    localparam int DELAY_W = 6;
    localparam int ACC_W   = DATA_W + clog2(NUM_CH);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multich_delay_sum_core_if #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DELAY_W(DELAY_W)
    ) bus ();

    multich_delay_sum_core #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int     checks = 0;
    int     errors = 0;
    int     tb_mode = 0;
    int     tb_d [NUM_CH];
    int     first_lat = 0;
    longint exp_y [$];

    // Sample patterns: 0 = (n+1)*10^c, 1 = n+1 on all, 2 = 0x80000000, 3 = signed ramp.
    function automatic logic [DATA_W-1:0] sample(input int mode, input int c, input int n);
        int scale;
        scale = (c == 0) ? 1 : (c == 1) ? 10 : 100;
        case (mode)
            0:       return DATA_W'((n + 1) * scale);
            1:       return DATA_W'(n + 1);
            2:       return 32'h8000_0000;
            default: return DATA_W'(n * 7 + 1000 * c - 500);
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.ram_rd_en === 1'b1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bus.ram_rd_data[c*DATA_W +: DATA_W] <= sample(tb_mode, c, int'(bus.ram_rd_addr));
            end
        end
    end

    function automatic longint model_y(input int n);
        longint s;
        s = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (n >= tb_d[c]) begin
                s += longint'($signed(sample(tb_mode, c, n - tb_d[c])));
            end
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_delay(input int ch, input int val);
        @(negedge clk);
        bus.dly_wr_en  = 1'b1;
        bus.dly_wr_ch  = 2'(ch);
        bus.dly_wr_val = DELAY_W'(val);
        @(negedge clk);
        bus.dly_wr_en  = 1'b0;
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2);
        set_delay(0, d0);
        set_delay(1, d1);
        set_delay(2, d2);
        tb_d[0] = d0;
        tb_d[1] = d1;
        tb_d[2] = d2;
    endtask

    task automatic start_frame(input int len);
        @(negedge clk);
        bus.frame_len = ADDR_W'(len);
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
    endtask

    task automatic collect_frame(input int len, input int hold_at, input string tag);
        int               cyc;
        logic [ACC_W-1:0] e;
        for (int i = 0; i < len; i++) begin
            e   = ACC_W'(exp_y[i]);
            cyc = 0;
            while (bus.out_valid !== 1'b1 && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            if (i == 0) first_lat = cyc + 1;
            check($sformatf("%s_valid%0d", tag, i), bus.out_valid, 1);
            if (i == hold_at) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("%s_hold_valid", tag), bus.out_valid, 1);
                    check($sformatf("%s_hold_data", tag), bus.out_data, e);
                    check($sformatf("%s_hold_index", tag), bus.out_index, i);
                    check($sformatf("%s_hold_no_read", tag), bus.ram_rd_en, 0);
                end
                bus.out_ready = 1'b1;
            end
            check($sformatf("%s_data%0d", tag, i), bus.out_data, e);
            check($sformatf("%s_index%0d", tag, i), bus.out_index, i);
            @(posedge clk);
            #1;
        end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("%s_done", tag), bus.done, 1);
        check($sformatf("%s_done_lat", tag), cyc, 1);
        check($sformatf("%s_busy_at_done", tag), bus.busy, 0);
        @(posedge clk);
        #1;
        check($sformatf("%s_done_pulse", tag), bus.done, 0);
    endtask

    initial begin
        int  cyc;
        bit  seen_valid;

        bus.start       = 1'b0;
        bus.frame_len   = '0;
        bus.dly_wr_en   = 1'b0;
        bus.dly_wr_ch   = '0;
        bus.dly_wr_val  = '0;
        bus.out_ready   = 1'b1;
        tb_d            = '{0, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_rd_en", bus.ram_rd_en, 0);
        check("rst_data", bus.out_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // Zero delays, scaled channels, then the same frame with backpressure on sample 2
        tb_mode = 0;
        exp_y = '{111, 222, 333, 444};
        start_frame(4);
        check("t1_busy", bus.busy, 1);
        collect_frame(4, -1, "t1");
        check("t1_first_lat", first_lat, 6);
        start_frame(4);
        collect_frame(4, 2, "t4");

        // Staggered delays 0/1/2
        tb_mode = 1;
        set_delays(0, 1, 2);
        exp_y = '{1, 3, 6, 9, 12};
        start_frame(5);
        collect_frame(5, -1, "t2");

        // Most-negative samples on every channel: -3*2^31 fits in 34 bits
        tb_mode = 2;
        set_delays(0, 0, 0);
        exp_y = '{-64'sd6442450944, -64'sd6442450944};
        start_frame(2);
        collect_frame(2, -1, "t3");
        check("t3_raw_bits", bus.out_data, 34'h2_8000_0000);

        // Empty frame: done two cycles after start, no output
        start_frame(0);
        cyc = 0;
        seen_valid = 1'b0;
        while (bus.done !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.out_valid === 1'b1) seen_valid = 1'b1;
        end
        check("t5_len0_done_lat", cyc + 1, 2);
        check("t5_len0_no_valid", seen_valid, 0);

        // Start and delay write while busy: both dropped, cfg_err raised
        tb_mode = 0;
        exp_y = '{111, 222, 333, 444};
        start_frame(4);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.frame_len  = '0;
        bus.dly_wr_en  = 1'b1;
        bus.dly_wr_ch  = 2'd1;
        bus.dly_wr_val = 6'd9;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.dly_wr_en  = 1'b0;
        check("t5_busy_cfg_err", bus.cfg_err, 1);
        check("t5_busy_still", bus.busy, 1);
        collect_frame(4, -1, "t5busy");
        check("t5_cfg_err_sticky", bus.cfg_err, 1);
        exp_y = '{111};
        start_frame(1);
        check("t5_cfg_err_cleared", bus.cfg_err, 0);
        collect_frame(1, -1, "t5next");
        set_delay(3, 5);
        check("t5_bad_ch_cfg_err", bus.cfg_err, 1);

        // History wrap with d1 = DEPTH-1 over a 200-sample ramp
        tb_mode = 3;
        set_delays(0, 63, 17);
        exp_y.delete();
        for (int n = 0; n < 200; n++) exp_y.push_back(model_y(n));
        start_frame(200);
        collect_frame(200, -1, "t6");

        // Same frame aborted by reset at n=100
        start_frame(200);
        cyc = 0;
        while (!(bus.out_valid === 1'b1 && bus.out_index == 11'd100) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t6_reached_n100", bus.out_index, 100);
        #2;
        rst = 1'b0;
        #1;
        check("t6_abort_valid", bus.out_valid, 0);
        check("t6_abort_busy", bus.busy, 0);
        check("t6_abort_done", bus.done, 0);
        check("t6_abort_rd_en", bus.ram_rd_en, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Recovery: delays are back to zero after reset
        tb_mode = 0;
        tb_d = '{0, 0, 0};
        exp_y = '{111};
        start_frame(1);
        collect_frame(1, -1, "t6rec");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
